spi_sclk_gen: RTL and testbench
===============================

# spi_sclk_gen

Parametrised SPI serial-clock generator, the successor to the fixed 8-bit divider. It produces one burst of `nbits` SCLK cycles per `start_i` and supports any divisor ≥ 2, including odd values with an asymmetric duty. It supports all four CPOL/CPHA modes and emits sample/shift strobes so the shift register never decodes SCLK itself. It sits between the APB register block (divider, mode and length fields) and the SPI shift/FIFO datapath.

## Interface
Parameters:
- `DIV_W`, default 8: divisor width; legal divisor 2..2^DIV_W-1.
- `CNT_W`, default 6: bit-count width; burst length 1..2^CNT_W-1.

Ports:
- `clk_i`  in  1  system clock. One clock; all logic on its rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `start_i`  in  1  start-burst pulse; sampled only in IDLE.
- `stop_i`  in  1  abort; highest priority in RUN.
- `div_i`  in  DIV_W  SCLK period in `clk_i` cycles.
- `nbits_i`  in  CNT_W  SCLK cycles in the burst.
- `cpol_i`  in  1  SCLK idle level.
- `cpha_i`  in  1  0: sample on leading edge; 1: sample on trailing edge.
- `sclk_o`  out  1  registered SCLK.
- `busy_o`  out  1  high in RUN.
- `lead_o`  out  1  1-cycle pulse in the cycle before SCLK leaves its idle level.
- `trail_o`  out  1  1-cycle pulse in the cycle before SCLK returns to its idle level.
- `sample_o`  out  1  MISO sample strobe.
- `shift_o`  out  1  MOSI shift strobe.
- `done_o`  out  1  1-cycle pulse on completion of the last bit.
- `cfg_err_o`  out  1  1-cycle pulse when `start_i` is rejected.

## Operation
- States: IDLE, RUN.
- Reset: state IDLE, `sclk_o`=0, all other outputs 0, counters 0.
- IDLE:
  - `sclk_o` <= `cpol_i` every cycle.
  - `start_i` with `div_i`≥2 and `nbits_i`≠0: latch `div`, `nbits`, `cpol`, `cpha`; clear counters; go to RUN.
  - `start_i` with `div_i`<2 or `nbits_i`=0: pulse `cfg_err_o` and stay in IDLE.
- RUN: each bit has phase A (idle level, L=div−⌊div/2⌋ cycles) followed by phase B (active level, H=⌊div/2⌋ cycles).
  - The half-period counter runs 0..len−1 and resets at each phase change.
  - Terminal count of phase A: `lead_o`=1; `sclk_o` toggles at the next edge.
  - Terminal count of phase B: `trail_o`=1; `sclk_o` toggles back; the bit counter increments.
  - Trailing pulse of bit `nbits`: `done_o`=1 in the same cycle, and the next state is IDLE.
- Strobe mapping:
  - CPHA=0: `sample_o`=`lead_o`; `shift_o`=`trail_o`, suppressed on the final trailing edge.
  - CPHA=1: `shift_o`=`lead_o`; `sample_o`=`trail_o`.
  - CPOL affects only the SCLK level, never the strobes.
- `stop_i` in RUN: next state IDLE and `sclk_o` <= latched cpol. No strobes and no `done_o` in that cycle. Takes priority over a coincident terminal count.
- `start_i` in RUN is ignored; there is no queuing.
- `div_i`, `nbits_i` and mode changes during RUN have no effect, because the latched copies are used.
- Arithmetic: divisor and counters are unsigned. The half-period counter is DIV_W bits and the bit counter is CNT_W bits. Counters never wrap within a legal burst.

## Timing
- `start_i` is sampled at edge 0; `busy_o`=1 from cycle 1.
- Bit k (0-based):
  - `lead_o` in cycle k·div+L.
  - `trail_o` in cycle (k+1)·div.
  - `sclk_o` is active during cycles k·div+L+1 .. (k+1)·div.
- `done_o` in cycle nbits·div; `busy_o`=0 and state IDLE from cycle nbits·div+1.
- A new `start_i` is accepted at the earliest in cycle nbits·div+1, giving back-to-back bursts with a one-cycle idle gap.
- Asserting `rst_i` mid-burst gives reset values at the next edge. No `done_o` is generated.

## Structure
- Shared package `spi_pkg`:
  - state enum {IDLE, RUN};
  - mode constants SPI_MODE0..3 as {cpol,cpha};
  - localparam `DIV_MIN`=2.
- One sub-module `spi_half_cnt`: loadable down-counter with terminal-count output. It is instantiated for the half-period; the bit counter stays inline.

## Test plan
- div=4, nbits=1, mode0, start at cycle 0 -> `lead_o` in cycle 2, `sclk_o` high in cycles 3–4, `trail_o`=`done_o` in cycle 4, `busy_o`=0 from cycle 5, `shift_o` never asserted.
- div=5, nbits=3, mode3 -> idle-high phase 3 cycles and low phase 2 cycles; `lead_o` in cycles 3,8,13; `sample_o`=`trail_o` in cycles 5,10,15; `done_o` in cycle 15.
- div=1 or nbits=0 with start -> `cfg_err_o` 1 cycle, `busy_o` stays 0, `sclk_o` unchanged.
- div=6, nbits=8, `stop_i` in cycle 20 -> IDLE in cycle 21, `sclk_o`=cpol, no `done_o`; a subsequent start in cycle 22 produces a normal burst.
- `rst_i` in cycle 10 of a div=4, nbits=4 burst -> all outputs 0 in cycle 11; `div_i` changed mid-burst -> period unchanged.
- Back-to-back: start re-asserted in the cycle `busy_o` falls -> accepted; second burst `lead_o` at (restart cycle)+L.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI serial-clock generator family.
package spi_pkg;

  // Burst controller states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } spi_state_e;

  // SPI modes encoded as {cpol, cpha}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Smallest divisor that still gives one clock per SCLK level.
  localparam int DIV_MIN = 2;

  // Phase A (idle level) gets the extra cycle when the divisor is odd.
  function automatic int unsigned phase_a_len(input int unsigned div);
    return div - (div / 2);
  endfunction

  // Phase B (active level) is the shorter half for odd divisors.
  function automatic int unsigned phase_b_len(input int unsigned div);
    return div / 2;
  endfunction

endpackage

// File: rtl/spi_half_cnt.sv
// Loadable down-counter that flags its terminal count (value zero).
// The owner loads len-1 at each phase change, so terminal count lands
// on the last cycle of the phase.
module spi_half_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_reg;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (load_i) begin
      cnt_reg <= load_val_i;
    end else if (en_i && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign tc_o = (cnt_reg == '0);

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: one burst of nbits SCLK cycles per start,
// any divisor >= 2, all four CPOL/CPHA modes, with sample/shift strobes
// so the datapath never has to decode SCLK edges itself.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [CNT_W-1:0] nbits_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  output logic             sclk_o,
  output logic             busy_o,
  output logic             lead_o,
  output logic             trail_o,
  output logic             sample_o,
  output logic             shift_o,
  output logic             done_o,
  output logic             cfg_err_o
);

  spi_state_e       state_reg, state_next;
  logic             phase_b_reg, phase_b_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic             sclk_reg, sclk_next;

  // Burst configuration captured at start so RUN ignores input changes.
  logic [DIV_W-1:0] div_reg;
  logic [CNT_W-1:0] nbits_reg;
  logic             cpol_reg;
  logic             cpha_reg;
  logic             cfg_latch;

  // Half-period counter control.
  logic             hc_load;
  logic [DIV_W-1:0] hc_load_val;
  logic             hc_en;
  logic             hc_tc;

  logic             lead_pulse;
  logic             trail_pulse;
  logic             done_pulse;
  logic             cfg_err_pulse;

  spi_half_cnt #(
    .W (DIV_W)
  ) u_half_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (hc_load),
    .load_val_i (hc_load_val),
    .en_i       (hc_en),
    .tc_o       (hc_tc)
  );

  // State, counters, SCLK level and latched burst configuration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      phase_b_reg <= 1'b0;
      bit_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
      div_reg     <= '0;
      nbits_reg   <= '0;
      cpol_reg    <= 1'b0;
      cpha_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      phase_b_reg <= phase_b_next;
      bit_cnt_reg <= bit_cnt_next;
      sclk_reg    <= sclk_next;
      if (cfg_latch) begin
        div_reg   <= div_i;
        nbits_reg <= nbits_i;
        cpol_reg  <= cpol_i;
        cpha_reg  <= cpha_i;
      end
    end
  end

  // Next-state, phase sequencing and edge pulses.
  always_comb begin
    state_next    = state_reg;
    phase_b_next  = phase_b_reg;
    bit_cnt_next  = bit_cnt_reg;
    sclk_next     = sclk_reg;
    cfg_latch     = 1'b0;
    hc_load       = 1'b0;
    hc_load_val   = '0;
    hc_en         = 1'b0;
    lead_pulse    = 1'b0;
    trail_pulse   = 1'b0;
    done_pulse    = 1'b0;
    cfg_err_pulse = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // SCLK tracks the requested idle level so mode changes show up
        // on the line before the first edge.
        sclk_next = cpol_i;
        if (start_i) begin
          if ((div_i >= DIV_W'(DIV_MIN)) && (nbits_i != '0)) begin
            cfg_latch    = 1'b1;
            state_next   = RUN;
            phase_b_next = 1'b0;
            bit_cnt_next = '0;
            hc_load      = 1'b1;
            hc_load_val  = DIV_W'(phase_a_len(32'(div_i)) - 1);
          end else begin
            cfg_err_pulse = 1'b1;
          end
        end
      end

      RUN: begin
        if (stop_i) begin
          // Abort wins over any coincident terminal count: no edges,
          // no strobes, no completion.
          state_next = IDLE;
          sclk_next  = cpol_reg;
        end else begin
          hc_en = 1'b1;
          if (hc_tc) begin
            hc_load = 1'b1;
            if (!phase_b_reg) begin
              lead_pulse   = 1'b1;
              sclk_next    = ~cpol_reg;
              phase_b_next = 1'b1;
              hc_load_val  = DIV_W'(phase_b_len(32'(div_reg)) - 1);
            end else begin
              trail_pulse  = 1'b1;
              sclk_next    = cpol_reg;
              phase_b_next = 1'b0;
              hc_load_val  = DIV_W'(phase_a_len(32'(div_reg)) - 1);
              if (bit_cnt_reg == (nbits_reg - CNT_W'(1))) begin
                done_pulse = 1'b1;
                state_next = IDLE;
              end else begin
                bit_cnt_next = bit_cnt_reg + CNT_W'(1);
              end
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // CPHA chooses which edge samples; the final trailing edge of a
  // CPHA=0 burst has no next bit to shift out.
  assign sample_o  = cpha_reg ? trail_pulse : lead_pulse;
  assign shift_o   = cpha_reg ? lead_pulse  : (trail_pulse & ~done_pulse);

  assign sclk_o    = sclk_reg;
  assign busy_o    = (state_reg == RUN);
  assign lead_o    = lead_pulse;
  assign trail_o   = trail_pulse;
  assign done_o    = done_pulse;
  assign cfg_err_o = cfg_err_pulse;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: table of burst configurations,
// hand sequences for abort/reset/back-to-back/config errors, and random
// bursts, all checked cycle by cycle against a timing-formula model.
module tb_spi_sclk_gen;
  import spi_pkg::*;

  logic       clk;
  logic       rst_i;
  logic       start_i;
  logic       stop_i;
  logic [7:0] div_i;
  logic [5:0] nbits_i;
  logic       cpol_i;
  logic       cpha_i;
  logic       sclk_o, busy_o, lead_o, trail_o, sample_o, shift_o, done_o, cfg_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  spi_sclk_gen dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .div_i     (div_i),
    .nbits_i   (nbits_i),
    .cpol_i    (cpol_i),
    .cpha_i    (cpha_i),
    .sclk_o    (sclk_o),
    .busy_o    (busy_o),
    .lead_o    (lead_o),
    .trail_o   (trail_o),
    .sample_o  (sample_o),
    .shift_o   (shift_o),
    .done_o    (done_o),
    .cfg_err_o (cfg_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {sclk, busy, lead, trail, sample, shift, done, cfg_err}
  function automatic logic [7:0] outs();
    return {sclk_o, busy_o, lead_o, trail_o, sample_o, shift_o, done_o, cfg_err_o};
  endfunction

  // Expected outputs t cycles after the start cycle (t=0), straight from
  // the burst timing formulas.
  function automatic logic [7:0] model(int t, int dv, int nb, bit pol, bit pha);
    int  l_len, total;
    bit  busy, act, ld, tr, dn, smp, sh;
    l_len = dv - dv / 2;
    total = dv * nb;
    busy  = (t >= 1) && (t <= total);
    act   = busy && (((t - 1) % dv) >= l_len);
    ld    = busy && ((t % dv) == l_len);
    tr    = busy && ((t % dv) == 0);
    dn    = (t == total);
    smp   = pha ? tr : ld;
    sh    = pha ? ld : (tr && !dn);
    return {pol ^ act, busy, ld, tr, smp, sh, dn, 1'b0};
  endfunction

  task automatic chk_vec(string name, int t, logic [7:0] got, logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got={sclk,busy,lead,trail,smp,shf,done,err}=%b expected=%b",
               name, t, got, exp);
    end
  endtask

  task automatic chk_int(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Runs one burst: optional idle pre-cycle, start in cycle 0, then
  // checks every cycle. Mid-burst it re-pulses start and scrambles
  // div/nbits/cpha, none of which may have any effect.
  task automatic run_burst(input int dv, input int nb, input bit pol, input bit pha,
                           input int stop_at, input int rst_at,
                           input bit do_pre, input bit do_tail,
                           output int lead0, output int done_c,
                           output int nl, output int ns, output int nsh);
    int         total, last_t;
    logic [7:0] got, exp;
    total  = dv * nb;
    lead0  = -1;
    done_c = -1;
    nl     = 0;
    ns     = 0;
    nsh    = 0;
    if (do_pre) begin
      @(posedge clk); #1;
      start_i = 1'b0; stop_i = 1'b0; cpol_i = pol; cpha_i = pha;
    end
    @(posedge clk); #1;
    div_i = 8'(dv); nbits_i = 6'(nb); cpol_i = pol; cpha_i = pha; start_i = 1'b1;
    #4;
    chk_vec("start_cycle", 0, outs(), model(0, dv, nb, pol, pha));
    if (stop_at > 0)      last_t = stop_at + 1;
    else if (rst_at > 0)  last_t = rst_at + 1;
    else if (do_tail)     last_t = total + 1;
    else                  last_t = total;
    for (int t = 1; t <= last_t; t++) begin
      @(posedge clk); #1;
      start_i = (t == 1);
      stop_i  = (t == stop_at);
      rst_i   = (t == rst_at);
      if (t == 2) begin
        div_i   = 8'(dv + 3);
        nbits_i = 6'(nb + 1);
        cpha_i  = ~pha;
      end
      #4;
      got = outs();
      if (rst_at > 0 && t == rst_at) continue;
      if (rst_at > 0 && t == rst_at + 1)        exp = 8'h00;
      else if (t == stop_at)                   exp = model(t, dv, nb, pol, pha) & 8'b1100_0000;
      else if (stop_at > 0 && t == stop_at + 1) exp = {pol, 7'b0};
      else                                     exp = model(t, dv, nb, pol, pha);
      chk_vec("burst", t, got, exp);
      if (got[5]) begin
        nl++;
        if (lead0 < 0) lead0 = t;
      end
      if (got[3]) ns++;
      if (got[2]) nsh++;
      if (got[1]) done_c = t;
    end
    start_i = 1'b0; stop_i = 1'b0; rst_i = 1'b0;
    $display("burst div=%0d nbits=%0d cpol=%0d cpha=%0d stop_at=%0d rst_at=%0d first_lead=%0d done_cycle=%0d",
             dv, nb, pol, pha, stop_at, rst_at, lead0, done_c);
  endtask

  typedef struct {
    int         dv;
    int         nb;
    logic [1:0] mode;
    int         lead0;
    int         done_c;
    int         n_lead;
    int         n_samp;
    int         n_shift;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lead0, done_c, nl, ns, nsh;
    int dv, nb, stop_at;
    bit pol, pha;
    logic [7:0] bad_div[3];
    logic [5:0] bad_nb[3];

    tbl[0] = '{4, 1, SPI_MODE0, 2, 4, 1, 1, 0};
    tbl[1] = '{5, 3, SPI_MODE3, 3, 15, 3, 3, 3};
    tbl[2] = '{2, 4, SPI_MODE1, 1, 8, 4, 4, 4};
    tbl[3] = '{3, 2, SPI_MODE2, 2, 6, 2, 2, 1};
    tbl[4] = '{6, 8, SPI_MODE0, 3, 48, 8, 8, 7};
    tbl[5] = '{7, 5, SPI_MODE1, 4, 35, 5, 5, 5};

    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    div_i = 8'd4; nbits_i = 6'd1; cpol_i = 1'b1; cpha_i = 1'b0;

    // Reset state: SCLK forced low regardless of cpol_i.
    @(posedge clk); #1;
    @(posedge clk); #1;
    #4;
    chk_vec("reset_state", 0, outs(), 8'h00);
    rst_i = 1'b0;
    @(posedge clk); #1; #4;
    chk_vec("idle_follows_cpol", 0, outs(), 8'b1000_0000);

    // Rejected starts: pulse cfg_err, stay idle, SCLK untouched.
    bad_div[0] = 8'd1; bad_nb[0] = 6'd3;
    bad_div[1] = 8'd5; bad_nb[1] = 6'd0;
    bad_div[2] = 8'd0; bad_nb[2] = 6'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      div_i = bad_div[i]; nbits_i = bad_nb[i]; start_i = 1'b1; #4;
      chk_vec("cfg_err_pulse", i, outs(), 8'b1000_0001);
      @(posedge clk); #1;
      start_i = 1'b0; #4;
      chk_vec("cfg_err_after", i, outs(), 8'b1000_0000);
      $display("cfg_err div=%0d nbits=%0d", bad_div[i], bad_nb[i]);
    end

    // Table-driven configurations.
    for (int i = 0; i < 6; i++) begin
      run_burst(tbl[i].dv, tbl[i].nb, tbl[i].mode[1], tbl[i].mode[0], 0, 0, 1'b1, 1'b1,
                lead0, done_c, nl, ns, nsh);
      chk_int("tbl_first_lead", lead0, tbl[i].lead0);
      chk_int("tbl_done_cycle", done_c, tbl[i].done_c);
      chk_int("tbl_lead_count", nl, tbl[i].n_lead);
      chk_int("tbl_sample_count", ns, tbl[i].n_samp);
      chk_int("tbl_shift_count", nsh, tbl[i].n_shift);
    end

    // Abort in cycle 20, restart in cycle 22 gives a full burst.
    run_burst(6, 8, 1'b0, 1'b0, 20, 0, 1'b1, 1'b1, lead0, done_c, nl, ns, nsh);
    chk_int("stop_no_done", done_c, -1);
    run_burst(6, 8, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, lead0, done_c, nl, ns, nsh);
    chk_int("restart_first_lead", lead0, 3);
    chk_int("restart_done", done_c, 48);

    // Reset mid-burst (idle-high mode so the forced-low SCLK is visible).
    run_burst(4, 4, 1'b1, 1'b0, 0, 10, 1'b1, 1'b1, lead0, done_c, nl, ns, nsh);
    chk_int("rst_no_done", done_c, -1);

    // Back-to-back: second start in the cycle busy falls.
    run_burst(4, 2, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, lead0, done_c, nl, ns, nsh);
    chk_int("b2b_first_done", done_c, 8);
    run_burst(3, 2, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, lead0, done_c, nl, ns, nsh);
    chk_int("b2b_second_lead", lead0, 2);
    chk_int("b2b_second_done", done_c, 6);

    // Random bursts, some aborted.
    for (int r = 0; r < 25; r++) begin
      dv  = int'($urandom_range(2, 12));
      nb  = int'($urandom_range(1, 8));
      pol = 1'($urandom_range(0, 1));
      pha = 1'($urandom_range(0, 1));
      stop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, dv * nb)) : 0;
      run_burst(dv, nb, pol, pha, stop_at, 0, 1'b1, 1'b1, lead0, done_c, nl, ns, nsh);
      if (stop_at == 0) chk_int("rand_lead_count", nl, nb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
